// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: branch condition codes,
// flag bit positions, PC-sequencer FSM encodings and the B-target helper.
package cpu_pkg;

  // Branch condition codes (br_cond field)
  localparam logic [2:0] NEQ    = 3'b000;
  localparam logic [2:0] EQ     = 3'b001;
  localparam logic [2:0] GT     = 3'b010;
  localparam logic [2:0] LT     = 3'b011;
  localparam logic [2:0] GTE    = 3'b100;
  localparam logic [2:0] LTE    = 3'b101;
  localparam logic [2:0] OVFL   = 3'b110;
  localparam logic [2:0] UNCOND = 3'b111;

  // Bit positions inside the {Z, V, N} flags vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // PC sequencer FSM states; the encoding is visible on the state port
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  // PC-relative target: word offset is sign-extended and scaled to bytes,
  // and the sum wraps modulo 2^16.
  function automatic logic [15:0] b_target(input logic [15:0] pc_plus2,
                                            input logic [8:0]  imm);
    logic [15:0] offset;
    offset   = {{6{imm[8]}}, imm, 1'b0};
    b_target = pc_plus2 + offset;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator against the {Z, V, N} flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z_s;
  logic v_s;
  logic n_s;

  assign z_s = flags[FLAG_Z];
  assign v_s = flags[FLAG_V];
  assign n_s = flags[FLAG_N];

  // Decode the condition code into a single taken/not-taken qualifier
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      NEQ:     cond_true = ~z_s;
      EQ:      cond_true = z_s;
      GT:      cond_true = ~z_s & ~n_s;
      LT:      cond_true = n_s;
      GTE:     cond_true = z_s | ~n_s;
      LTE:     cond_true = z_s | n_s;
      OVFL:    cond_true = v_s;
      UNCOND:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: resolves B/BR in decode, honours
// hazard stalls, kills the wrong-path fetch and parks the core on HLT.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [15:0] id_pc_plus2,
  input  logic        br_valid,
  input  logic        br_reg_valid,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_reg_target,
  input  logic [2:0]  flags,
  input  logic        hlt_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_en,
  output logic        flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] br_taken_cnt
);

  seq_state_e  state_r;
  logic [15:0] pc_r;
  logic [15:0] cnt_r;
  logic        halted_r;
  logic        fetch_en_r;

  logic        cond_true_s;
  logic        taken_s;
  logic        active_s;
  logic [15:0] target_s;
  logic [15:0] pc_inc_s;
  logic        flush_s;

  branch_cond_eval u_cond (
    .br_cond   (br_cond),
    .flags     (flags),
    .cond_true (cond_true_s)
  );

  // Branch resolution, target selection and wrong-path kill
  always_comb begin
    active_s = (state_r != ST_HALT);
    taken_s  = (br_valid | br_reg_valid) & cond_true_s;
    pc_inc_s = pc_r + 16'd2;
    // B wins if decode ever flags both branch kinds at once
    if (br_valid) begin
      target_s = b_target(id_pc_plus2, br_imm);
    end else begin
      target_s = br_reg_target;
    end
    flush_s = (taken_s | hlt_valid) & ~stall & active_s;
  end

  // Sequencer FSM: PC update, stall hold and halt parking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      halted_r   <= 1'b0;
      fetch_en_r <= 1'b1;
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (hlt_valid && !stall) begin
            // HLT beats any branch in the same slot; PC stays put
            state_r    <= ST_HALT;
            halted_r   <= 1'b1;
            fetch_en_r <= 1'b0;
          end else if (stall) begin
            state_r <= ST_STALL;
          end else if (taken_s) begin
            state_r <= ST_RUN;
            pc_r    <= target_s;
          end else begin
            state_r <= ST_RUN;
            pc_r    <= pc_inc_s;
          end
        end
        ST_HALT: begin
          // Only rst_n leaves HALT
          state_r    <= ST_HALT;
          halted_r   <= 1'b1;
          fetch_en_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_HALT;
          halted_r   <= 1'b1;
          fetch_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating debug count of resolved taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'h0000;
    end else if (taken_s && !stall && active_s && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign pc           = pc_r;
  assign pc_plus2     = pc_inc_s;
  assign fetch_en     = fetch_en_r;
  assign flush        = flush_s;
  assign halted       = halted_r;
  assign state        = state_r;
  assign br_taken_cnt = cnt_r;

endmodule
